// File: rtl/multiboot_icap_sequencer.sv
// Spartan-3A MultiBoot sequencer: streams sync / GENERAL1-2 / REBOOT words onto the ICAP pins.
// Optional arm-key gate on start is enabled with `define MULTIBOOT_SEQ_ARM_EN.
module multiboot_icap_sequencer #(
    parameter int ICAP_W   = 8,
    parameter int CLK_DIV  = 3,
    parameter int PRE_LEN  = 2,
    parameter int POST_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [23:0]       boot_addr,
    input  logic [7:0]        read_opcode,
    input  logic              arm_valid,
    input  logic [15:0]       arm_key,
    output logic              busy,
    output logic              done,
    output logic              rejected,
    output logic              icap_clk,
    output logic              icap_ce_n,
    output logic              icap_write_n,
    output logic [ICAP_W-1:0] icap_i
);

    localparam int BPW     = 16 / ICAP_W;
    localparam int CMD_LEN = 8 * BPW;
    localparam int N_XFER  = PRE_LEN + CMD_LEN + POST_LEN;
    localparam int PH_W    = $clog2(CLK_DIV);
    localparam int XF_W    = $clog2(N_XFER + 1);

    localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [XF_W-1:0] XF_LAST   = XF_W'(N_XFER - 1);
    localparam logic [XF_W-1:0] CMD_FIRST = XF_W'(PRE_LEN);
    localparam logic [XF_W-1:0] CMD_END   = XF_W'(PRE_LEN + CMD_LEN);

    if (ICAP_W != 8 && ICAP_W != 16) begin : g_bad_width
        $error("multiboot_icap_sequencer: ICAP_W must be 8 or 16");
    end
    if (CLK_DIV < 3) begin : g_bad_div
        $error("multiboot_icap_sequencer: CLK_DIV must be at least 3");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [XF_W-1:0]   xfer_q, xfer_d;
    logic [23:0]       addr_q, addr_d;
    logic [7:0]        op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rej_q, rej_d;
    logic              iclk_q, iclk_d;
    logic              ce_n_q, ce_n_d;
    logic              wr_n_q, wr_n_d;
    logic [ICAP_W-1:0] dat_q, dat_d;
    logic              accept;

    // Command word/byte selection for the transfer currently being set up.
    logic              in_cmd;
    logic [XF_W-1:0]   cmd_idx;
    logic [2:0]        word_sel;
    logic [15:0]       word;
    logic [ICAP_W-1:0] raw;
    logic [ICAP_W-1:0] rev;

    assign in_cmd   = (xfer_q >= CMD_FIRST) && (xfer_q < CMD_END);
    assign cmd_idx  = xfer_q - CMD_FIRST;
    assign word_sel = 3'(cmd_idx >> (BPW - 1));

    always_comb begin
        word = 16'h0000;
        case (word_sel)
            3'd0: word = 16'hAA99;
            3'd1: word = 16'h3261;
            3'd2: word = addr_q[15:0];
            3'd3: word = 16'h3281;
            3'd4: word = {op_q, addr_q[23:16]};
            3'd5: word = 16'h30A1;
            3'd6: word = 16'h000E;
            3'd7: word = 16'h2000;
            default: word = 16'h0000;
        endcase
    end

    // Byte-wide port sends the high byte of each word first.
    if (ICAP_W == 8) begin : g_w8
        assign raw = cmd_idx[0] ? word[7:0] : word[15:8];
    end else begin : g_w16
        assign raw = word;
    end

    // ICAP expects each byte bit-swapped relative to the bitstream byte order.
    always_comb begin
        rev = '0;
        for (int k = 0; k < ICAP_W / 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                rev[8*k + j] = raw[8*k + 7 - j];
            end
        end
    end

`ifdef MULTIBOOT_SEQ_ARM_EN
    localparam logic [15:0] ARM_KEY = 16'h5A3C;
    logic armed_q, armed_d;
`else
    logic unused_arm;
    assign unused_arm = ^{arm_valid, arm_key};
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        xfer_d  = xfer_q;
        addr_d  = addr_q;
        op_d    = op_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rej_d   = 1'b0;
        iclk_d  = 1'b0;
        ce_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        dat_d   = '0;
        accept  = 1'b0;
`ifdef MULTIBOOT_SEQ_ARM_EN
        armed_d = armed_q;
`endif

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
`ifdef MULTIBOOT_SEQ_ARM_EN
                    if (armed_q) begin
                        accept = 1'b1;
                    end else begin
                        rej_d = 1'b1;
                    end
`else
                    accept = 1'b1;
`endif
                end
                if (accept) begin
                    state_d = S_RUN;
                    phase_d = '0;
                    xfer_d  = '0;
                    addr_d  = boot_addr;
                    op_d    = read_opcode;
                    busy_d  = 1'b1;
`ifdef MULTIBOOT_SEQ_ARM_EN
                    armed_d = 1'b0;
`endif
                end
            end

            S_RUN: begin
                // Pin values are a registered copy of the current phase/transfer,
                // so data settles one cycle before the strobe rises.
                iclk_d = (phase_q == PH_ONE);
                if (in_cmd) begin
                    ce_n_d = 1'b0;
                    wr_n_d = 1'b0;
                    dat_d  = rev;
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (xfer_q == XF_LAST) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                    end else begin
                        xfer_d = xfer_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MULTIBOOT_SEQ_ARM_EN
        if (arm_valid) begin
            if (arm_key == ARM_KEY) begin
                armed_d = 1'b1;
            end else begin
                armed_d = 1'b0;
                rej_d   = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            xfer_q  <= '0;
            addr_q  <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
            iclk_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            xfer_q  <= xfer_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
            iclk_q  <= iclk_d;
            ce_n_q  <= ce_n_d;
            wr_n_q  <= wr_n_d;
            dat_q   <= dat_d;
        end
    end

`ifdef MULTIBOOT_SEQ_ARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign rejected     = rej_q;
    assign icap_clk     = iclk_q;
    assign icap_ce_n    = ce_n_q;
    assign icap_write_n = wr_n_q;
    assign icap_i       = dat_q;

endmodule

// File: tb/tb_multiboot_icap_sequencer.sv
// Bench for multiboot_icap_sequencer: byte-wide (default) and word-wide (CLK_DIV=4) instances
// checked against a stream model built from the command-word list.
module tb_multiboot_icap_sequencer;

    localparam int PRE  = 2;
    localparam int POST = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [23:0] boot_addr = '0;
    logic [7:0]  read_opcode = '0;
    logic        arm_valid = 1'b0;
    logic [15:0] arm_key = '0;

    logic        busy8, done8, rej8, iclk8, ce8, wr8;
    logic [7:0]  dat8;
    logic        busy16, done16, rej16, iclk16, ce16, wr16;
    logic [15:0] dat16;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multiboot_icap_sequencer #(.ICAP_W(8), .CLK_DIV(3), .PRE_LEN(PRE), .POST_LEN(POST)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .boot_addr(boot_addr),
        .read_opcode(read_opcode), .arm_valid(arm_valid), .arm_key(arm_key),
        .busy(busy8), .done(done8), .rejected(rej8), .icap_clk(iclk8),
        .icap_ce_n(ce8), .icap_write_n(wr8), .icap_i(dat8)
    );

    multiboot_icap_sequencer #(.ICAP_W(16), .CLK_DIV(4), .PRE_LEN(PRE), .POST_LEN(POST)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .boot_addr(boot_addr),
        .read_opcode(read_opcode), .arm_valid(arm_valid), .arm_key(arm_key),
        .busy(busy16), .done(done16), .rejected(rej16), .icap_clk(iclk16),
        .icap_ce_n(ce16), .icap_write_n(wr16), .icap_i(dat16)
    );

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = b[7-j];
        return r;
    endfunction

    task automatic arm_if_needed();
`ifdef MULTIBOOT_SEQ_ARM_EN
        @(negedge clk);
        arm_valid = 1'b1;
        arm_key   = 16'h5A3C;
        @(posedge clk); #1;
        arm_valid = 1'b0;
        n_checks++;
        if (rej8 !== 1'b0 || rej16 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_good_key: rejected8=%b rejected16=%b want 0", rej8, rej16);
        end
`endif
    endtask

    // Starts one sequence on the chosen instance and checks every strobe against the model.
    task automatic run_and_check(input bit wide, input logic [23:0] addr, input logic [7:0] op,
                                 input int restart_at, input string tag);
        logic [15:0] words [8];
        logic [15:0] exp_dat [$];
        bit          exp_cmd [$];
        int          d, n, strobes, done_cnt, limit;
        bit          prev_clk, rej_seen;
        logic        c_clk, c_ce, c_wr, c_busy, c_done, c_rej;
        logic [15:0] c_dat;

        d = wide ? 4 : 3;
        words[0] = 16'hAA99;
        words[1] = 16'h3261;
        words[2] = addr[15:0];
        words[3] = 16'h3281;
        words[4] = {op, addr[23:16]};
        words[5] = 16'h30A1;
        words[6] = 16'h000E;
        words[7] = 16'h2000;
        for (int i = 0; i < PRE; i++) begin exp_dat.push_back(16'h0); exp_cmd.push_back(1'b0); end
        for (int i = 0; i < 8; i++) begin
            if (wide) begin
                exp_dat.push_back({rev8(words[i][15:8]), rev8(words[i][7:0])});
                exp_cmd.push_back(1'b1);
            end else begin
                exp_dat.push_back({8'h00, rev8(words[i][15:8])});
                exp_cmd.push_back(1'b1);
                exp_dat.push_back({8'h00, rev8(words[i][7:0])});
                exp_cmd.push_back(1'b1);
            end
        end
        for (int i = 0; i < POST; i++) begin exp_dat.push_back(16'h0); exp_cmd.push_back(1'b0); end
        n = exp_dat.size();

        arm_if_needed();
        @(negedge clk);
        boot_addr   = addr;
        read_opcode = op;
        if (wide) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        start16 = 1'b0;

        strobes = 0; done_cnt = 0; prev_clk = 1'b0; rej_seen = 1'b0;
        limit = n * d + 4;
        for (int c = 1; c <= limit; c++) begin
            boot_addr   = 24'($urandom);
            read_opcode = 8'($urandom);
            if (c == restart_at) begin
                if (wide) start16 = 1'b1; else start8 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            start16 = 1'b0;
            c_clk  = wide ? iclk16 : iclk8;
            c_ce   = wide ? ce16 : ce8;
            c_wr   = wide ? wr16 : wr8;
            c_busy = wide ? busy16 : busy8;
            c_done = wide ? done16 : done8;
            c_rej  = wide ? rej16 : rej8;
            c_dat  = wide ? dat16 : {8'h00, dat8};
            if (c_rej !== 1'b0) rej_seen = 1'b1;
            if (c == 1) begin
                n_checks++;
                if (c_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_after_start: got %b want 1", tag, c_busy);
                end
            end
            if (c_clk === 1'b1 && prev_clk === 1'b0) begin
                if (strobes < n) begin
                    n_checks++;
                    if (c != 2 + strobes * d) begin
                        n_fail++;
                        $display("FAIL %s strobe%0d_time: got cycle %0d want %0d", tag, strobes, c, 2 + strobes * d);
                    end
                    n_checks++;
                    if (c_dat !== exp_dat[strobes] || c_ce !== !exp_cmd[strobes] || c_wr !== !exp_cmd[strobes]) begin
                        n_fail++;
                        $display("FAIL %s strobe%0d_pins: got dat=%h ce_n=%b wr_n=%b want dat=%h ce_n=%b wr_n=%b",
                                 tag, strobes, c_dat, c_ce, c_wr, exp_dat[strobes], !exp_cmd[strobes], !exp_cmd[strobes]);
                    end
                end
                strobes++;
            end
            prev_clk = c_clk;
            if (c_done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    n_checks++;
                    if (c != n * d + 1 || c_busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s done_time: got cycle %0d busy=%b want cycle %0d busy=0", tag, c, c_busy, n * d + 1);
                    end
                end
            end
        end

        n_checks++;
        if (strobes != n || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s counts: got strobes=%0d dones=%0d want %0d and 1", tag, strobes, done_cnt, n);
        end
        n_checks++;
        if (rej_seen !== 1'b0 || c_ce !== 1'b1 || c_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end_state: got rej_seen=%b ce_n=%b busy=%b want 0 1 0", tag, rej_seen, c_ce, c_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, rej8, iclk8, ce8, wr8, dat8} !== {6'b000011, 8'h00}) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b rej=%b clk=%b ce_n=%b wr_n=%b dat=%h want 0 0 0 0 1 1 00",
                     busy8, done8, rej8, iclk8, ce8, wr8, dat8);
        end
        n_checks++;
        if ({busy16, done16, rej16, iclk16, ce16, wr16, dat16} !== {6'b000011, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset16: got busy=%b done=%b rej=%b clk=%b ce_n=%b wr_n=%b dat=%h want 0 0 0 0 1 1 0000",
                     busy16, done16, rej16, iclk16, ce16, wr16, dat16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || iclk8 !== 1'b0 || ce8 !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b clk=%b ce_n=%b want 0 0 1", busy8, iclk8, ce8);
        end
    endtask

    task automatic test_stream_w8();
        run_and_check(1'b0, 24'h010000, 8'h0B, -1, "w8_plan");
        for (int i = 0; i < 3; i++)
            run_and_check(1'b0, 24'($urandom), 8'($urandom), -1, "w8_rand");
    endtask

    task automatic test_stream_w16();
        run_and_check(1'b1, 24'h123456, 8'h03, -1, "w16_plan");
        for (int i = 0; i < 2; i++)
            run_and_check(1'b1, 24'($urandom), 8'($urandom), -1, "w16_rand");
    endtask

    task automatic test_back_to_back();
        run_and_check(1'b0, 24'hABCDEF, 8'h0B, 10, "restart_ignored");
        run_and_check(1'b0, 24'h00FF00, 8'h0B, -1, "second_run");
    endtask

    task automatic test_reset_mid_run();
        int  strobes;
        bit  prev_clk, done_seen;
        arm_if_needed();
        @(negedge clk);
        boot_addr = 24'h0A0B0C;
        read_opcode = 8'h0B;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        strobes = 0; prev_clk = 1'b0;
        for (int c = 0; c < 200 && strobes < 9; c++) begin
            @(posedge clk); #1;
            if (iclk8 === 1'b1 && prev_clk === 1'b0) strobes++;
            prev_clk = iclk8;
        end
        n_checks++;
        if (strobes != 9) begin
            n_fail++;
            $display("FAIL midrun_reach_strobe9: got %0d strobes want 9", strobes);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ce8 !== 1'b1 || wr8 !== 1'b1 || iclk8 !== 1'b0 || busy8 !== 1'b0 || dat8 !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got ce_n=%b wr_n=%b clk=%b busy=%b dat=%h want 1 1 0 0 00",
                     ce8, wr8, iclk8, busy8, dat8);
        end
        done_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done8 !== 1'b0) done_seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) begin
            @(posedge clk); #1;
            if (done8 !== 1'b0 || busy8 !== 1'b0) done_seen = 1'b1;
        end
        n_checks++;
        if (done_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got done/busy activity=%b want 0", done_seen);
        end
        run_and_check(1'b0, 24'($urandom), 8'($urandom), -1, "after_reset");
    endtask

`ifdef MULTIBOOT_SEQ_ARM_EN
    task automatic test_arm();
        bit active;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++;
        if (rej8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_unarmed_start: got rej=%b busy=%b want 1 0", rej8, busy8);
        end
        active = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (iclk8 !== 1'b0 || busy8 !== 1'b0) active = 1'b1;
        end
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_no_strobes: got activity=%b want 0", active);
        end
        @(negedge clk); arm_valid = 1'b1; arm_key = 16'h1234;
        @(posedge clk); #1;
        arm_valid = 1'b0;
        n_checks++;
        if (rej8 !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_bad_key: got rej=%b want 1", rej8);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rej8 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_rej_pulse_width: got rej=%b want 0", rej8);
        end
        run_and_check(1'b0, 24'h020000, 8'h0B, -1, "arm_good");
        @(negedge clk); start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++;
        if (rej8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_consumed: got rej=%b busy=%b want 1 0", rej8, busy8);
        end
    endtask
`else
    task automatic test_arm();
        @(negedge clk); arm_valid = 1'b1; arm_key = 16'h1234;
        @(posedge clk); #1;
        arm_valid = 1'b0;
        n_checks++;
        if (rej8 !== 1'b0 || rej16 !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_ignored: got rej8=%b rej16=%b want 0 0", rej8, rej16);
        end
        run_and_check(1'b0, 24'($urandom), 8'($urandom), -1, "unarmed_start");
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream_w8();
        test_stream_w16();
        test_back_to_back();
        test_reset_mid_run();
        test_arm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
